// File: rtl/servo_pwm_gen.sv
// Servo PWM frame generator: one pulse per PERIOD-cycle frame, with the pulse
// width latched (and clamped to [MIN_W, MAX_W]) only at frame boundaries.
module servo_pwm_gen #(
    parameter int unsigned PERIOD = 1000000,
    parameter int unsigned MIN_W  = 18000,
    parameter int unsigned MAX_W  = 130000,
    parameter int unsigned INIT_W = 74250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [18:0] width_in,
    output logic        pwm_o,
    output logic        frame_start,
    output logic [18:0] width_act,
    output logic        clamped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [19:0] LAST_CNT = 20'(PERIOD - 1);
    localparam logic [18:0] MIN_V    = 19'(MIN_W);
    localparam logic [18:0] MAX_V    = 19'(MAX_W);
    localparam logic [18:0] INIT_V   = 19'(INIT_W);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [19:0] cnt_r;
    logic [19:0] cnt_nxt_s;
    logic [19:0] cnt_inc_s;
    logic        start_s;
    logic [18:0] clamp_w_s;
    logic        clamp_f_s;
    logic        pwm_r;
    logic        pwm_nxt_s;
    logic        frame_start_r;
    logic [18:0] width_act_r;
    logic [18:0] width_nxt_s;
    logic        clamped_r;
    logic        clamped_nxt_s;

    function automatic logic [18:0] clamp_width(input logic [18:0] w);
        if (w < MIN_V) begin
            return MIN_V;
        end else if (w > MAX_V) begin
            return MAX_V;
        end else begin
            return w;
        end
    endfunction

    function automatic logic out_of_range(input logic [18:0] w);
        return (w < MIN_V) || (w > MAX_V);
    endfunction

    assign clamp_w_s = clamp_width(width_in);
    assign clamp_f_s = out_of_range(width_in);
    assign cnt_inc_s = cnt_r + 20'd1;

    // State and frame counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 20'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state: frame starts come from IDLE or from the last cycle of a frame
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        start_s     = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = 20'd0;
                if (en) begin
                    start_s     = 1'b1;
                    state_nxt_s = (clamp_w_s != 19'd0) ? HIGH : LOW;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HIGH, LOW: begin
                if (cnt_r == LAST_CNT) begin
                    cnt_nxt_s = 20'd0;
                    if (en) begin
                        start_s     = 1'b1;
                        state_nxt_s = (clamp_w_s != 19'd0) ? HIGH : LOW;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                    state_nxt_s = (cnt_inc_s < {1'b0, width_act_r}) ? HIGH : LOW;
                end
            end
            default: begin
                cnt_nxt_s   = 20'd0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: width/clamp status only change on a frame start
    always_comb begin
        pwm_nxt_s     = (state_nxt_s == HIGH);
        width_nxt_s   = width_act_r;
        clamped_nxt_s = clamped_r;
        if (start_s) begin
            width_nxt_s   = clamp_w_s;
            clamped_nxt_s = clamp_f_s;
        end else begin
            width_nxt_s   = width_act_r;
            clamped_nxt_s = clamped_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r         <= 1'b0;
            frame_start_r <= 1'b0;
            width_act_r   <= INIT_V;
            clamped_r     <= 1'b0;
        end else begin
            pwm_r         <= pwm_nxt_s;
            frame_start_r <= start_s;
            width_act_r   <= width_nxt_s;
            clamped_r     <= clamped_nxt_s;
        end
    end

    assign pwm_o       = pwm_r;
    assign frame_start = frame_start_r;
    assign width_act   = width_act_r;
    assign clamped     = clamped_r;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen using scaled parameters 1000/18/130/74.
module tb_servo_pwm_gen;

    localparam int PER  = 1000;
    localparam int MINW = 18;
    localparam int MAXW = 130;
    localparam int INIW = 74;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [18:0] width_in;
    logic        pwm_o;
    logic        frame_start;
    logic [18:0] width_act;
    logic        clamped;

    int checks = 0;
    int errors = 0;

    servo_pwm_gen #(
        .PERIOD(PER),
        .MIN_W (MINW),
        .MAX_W (MAXW),
        .INIT_W(INIW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .width_in   (width_in),
        .pwm_o      (pwm_o),
        .frame_start(frame_start),
        .width_act  (width_act),
        .clamped    (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run from a frame_start cycle to the next one (bounded), counting pulse cycles.
    task automatic measure(output int hi, output int per);
        hi  = 0;
        per = 0;
        do begin
            if (pwm_o === 1'b1) hi++;
            tick();
            per++;
        end while (frame_start !== 1'b1 && per < 1500);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        width_in = 19'd74;
        #12;
        checks++; if (pwm_o !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm_o); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        checks++; if (width_act !== 19'd74) begin errors++; $display("FAIL reset_width: got %0d want 74", width_act); end
        checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL reset_clamped: got %b want 0", clamped); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (frame_start !== 1'b0 || pwm_o !== 1'b0) begin errors++; $display("FAIL idle_hold: got fs=%b pwm=%b want 0/0", frame_start, pwm_o); end
    endtask

    task automatic test_basic();
        int hi, per;
        width_in = 19'd74;
        en       = 1'b1;
        tick();
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL start_latency: got fs=%b want 1", frame_start); end
        checks++; if (pwm_o !== 1'b1) begin errors++; $display("FAIL start_pwm: got %b want 1", pwm_o); end
        checks++; if (width_act !== 19'd74 || clamped !== 1'b0) begin errors++; $display("FAIL start_width: got %0d/%b want 74/0", width_act, clamped); end
        tick();
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL strobe_len: got fs=%b want 0", frame_start); end
        measure(hi, per);
        checks++; if (hi !== 73) begin errors++; $display("FAIL basic_high: got %0d want 73 (after first cycle)", hi); end
        checks++; if (per !== PER - 1) begin errors++; $display("FAIL basic_period: got %0d want %0d", per, PER - 1); end
    endtask

    task automatic test_clamp();
        int hi, per, prev;
        logic [18:0] vin [4];
        logic [18:0] vexp[4];
        logic        cexp[4];
        vin  = '{19'd5, 19'd200, 19'd18, 19'd130};
        vexp = '{19'd18, 19'd130, 19'd18, 19'd130};
        cexp = '{1'b1, 1'b1, 1'b0, 1'b0};
        prev = INIW;
        // Width requested now is latched at the next frame start; previous frame is measured.
        for (int i = 0; i < 4; i++) begin
            width_in = vin[i];
            measure(hi, per);
            checks++; if (width_act !== vexp[i] || clamped !== cexp[i]) begin errors++; $display("FAIL clamp_%0d: got %0d/%b want %0d/%b", i, width_act, clamped, vexp[i], cexp[i]); end
            checks++; if (hi !== prev || per !== PER) begin errors++; $display("FAIL clamp_frame_%0d: got hi=%0d per=%0d want %0d/%0d", i, hi, per, prev, PER); end
            prev = int'(vexp[i]);
        end
    endtask

    task automatic test_width_change();
        int hi, per;
        width_in = 19'd50;
        measure(hi, per);
        checks++; if (hi !== MAXW) begin errors++; $display("FAIL wc_prev_high: got %0d want %0d", hi, MAXW); end
        hi  = 0;
        per = 0;
        do begin
            if (per == 20) width_in = 19'd100;
            if (per == 500) begin
                checks++; if (width_act !== 19'd50) begin errors++; $display("FAIL wc_mid_width: got %0d want 50", width_act); end
            end
            if (pwm_o === 1'b1) hi++;
            tick();
            per++;
        end while (frame_start !== 1'b1 && per < 1500);
        checks++; if (hi !== 50 || per !== PER) begin errors++; $display("FAIL wc_cur_frame: got hi=%0d per=%0d want 50/%0d", hi, per, PER); end
        checks++; if (width_act !== 19'd100) begin errors++; $display("FAIL wc_next_width: got %0d want 100", width_act); end
        measure(hi, per);
        checks++; if (hi !== 100) begin errors++; $display("FAIL wc_next_high: got %0d want 100", hi); end
    endtask

    task automatic test_en_drop();
        int hi, starts;
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            if (i == 500) en = 1'b0;
            if (pwm_o === 1'b1) hi++;
            tick();
        end
        checks++; if (hi !== 100) begin errors++; $display("FAIL drop_high: got %0d want 100", hi); end
        checks++; if (frame_start !== 1'b0 || pwm_o !== 1'b0) begin errors++; $display("FAIL drop_idle: got fs=%b pwm=%b want 0/0", frame_start, pwm_o); end
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame_start === 1'b1 || pwm_o === 1'b1) starts++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL drop_quiet: got %0d active cycles want 0", starts); end
        en = 1'b1;
        tick();
        checks++; if (frame_start !== 1'b1 || pwm_o !== 1'b1) begin errors++; $display("FAIL reraise: got fs=%b pwm=%b want 1/1", frame_start, pwm_o); end
    endtask

    task automatic test_en_last_cycle();
        int hi;
        en = 1'b0;
        hi = 0;
        for (int i = 0; i < PER - 1; i++) begin
            if (pwm_o === 1'b1) hi++;
            tick();
        end
        checks++; if (hi !== 100) begin errors++; $display("FAIL early_drop_high: got %0d want 100", hi); end
        width_in = 19'd5;
        en       = 1'b1;
        tick();
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL last_cycle_reassert: got fs=%b want 1", frame_start); end
        checks++; if (width_act !== 19'd18 || clamped !== 1'b1) begin errors++; $display("FAIL last_cycle_width: got %0d/%b want 18/1", width_act, clamped); end
    endtask

    task automatic test_reset_midpulse();
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pwm_o !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm: got %b want 1", pwm_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pwm_o !== 1'b0) begin errors++; $display("FAIL async_reset_pwm: got %b want 0", pwm_o); end
        checks++; if (width_act !== 19'd74 || clamped !== 1'b0) begin errors++; $display("FAIL async_reset_width: got %0d/%b want 74/0", width_act, clamped); end
        en = 1'b0;
        width_in = 19'd74;
        #10;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (frame_start !== 1'b0 || pwm_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got fs=%b pwm=%b want 0/0", frame_start, pwm_o); end
        en = 1'b1;
        tick();
        checks++; if (frame_start !== 1'b1 || pwm_o !== 1'b1) begin errors++; $display("FAIL post_reset_start: got fs=%b pwm=%b want 1/1", frame_start, pwm_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_width_change();
        test_en_drop();
        test_en_last_cycle();
        test_reset_midpulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
